// File: rtl/adc_capture_buffer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | adc_capture_buffer: triggered, decimated dual-channel snapshot RAM     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module adc_capture_buffer #(
  parameter int AW = 10,
  parameter int DW = 12
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic [DW-1:0]   adc_ch0,
  input  logic [DW-1:0]   adc_ch1,
  input  logic            sample_valid,
  input  logic            arm,
  input  logic            abort,
  input  logic [1:0]      trig_mode,
  input  logic [DW-1:0]   trig_level,
  input  logic            ext_trig,
  input  logic [7:0]      decim,
  input  logic [AW-1:0]   length,
  output logic            busy,
  output logic            done,
  output logic [1:0]      state,
  output logic [AW:0]     wr_count,
  input  logic [AW-1:0]   rd_addr,
  output logic [2*DW-1:0] rd_data
);

  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_ARMED   = 2'b01;
  localparam logic [1:0] S_CAPTURE = 2'b10;
  localparam logic [1:0] S_DONE    = 2'b11;

  localparam logic [1:0] M_IMM  = 2'b00;
  localparam logic [1:0] M_RISE = 2'b01;
  localparam logic [1:0] M_FALL = 2'b10;

  localparam logic [AW:0] FULL_DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE_PAIR   = {{AW{1'b0}}, 1'b1};

  logic [1:0]      cur_state;
  logic [1:0]      nxt_state;

  // Configuration latched at arm time
  logic [1:0]      mode_sh;
  logic [DW-1:0]   level_sh;
  logic [7:0]      decim_sh;
  logic [AW:0]     len_sh;

  logic            prev_ok;
  logic [DW-1:0]   prev_ch0;
  logic [7:0]      dcnt;
  logic [AW:0]     count;
  logic            done_r;
  logic            busy_r;
  logic [2*DW-1:0] rd_q;
  logic [2*DW-1:0] mem [0:(1<<AW)-1];

  logic            hit;
  logic            dec_hit;
  logic            arm_take;
  logic            capture_trig;
  logic            capture_step;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [2*DW-1:0] wr_word;
  logic [AW:0]     count_inc;

  assign dec_hit   = (dcnt == decim_sh);
  assign count_inc = count + ONE_PAIR;
  assign arm_take  = arm && !abort && ((cur_state == S_IDLE) || (cur_state == S_DONE));

  // Crossing modes need a primed previous sample before they may fire
  always_comb begin
    hit = 1'b0;
    case (mode_sh)
      M_IMM:   hit = 1'b1;
      M_RISE:  hit = prev_ok && ($signed(prev_ch0) < $signed(level_sh))
                             && ($signed(adc_ch0) >= $signed(level_sh));
      M_FALL:  hit = prev_ok && ($signed(prev_ch0) > $signed(level_sh))
                             && ($signed(adc_ch0) <= $signed(level_sh));
      default: hit = ext_trig;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cur_state <= S_IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    if (abort) begin
      nxt_state = S_IDLE;
    end else begin
      case (cur_state)
        S_IDLE, S_DONE: begin
          if (arm) nxt_state = S_ARMED;
        end
        S_ARMED: begin
          if (sample_valid && hit) nxt_state = (len_sh == ONE_PAIR) ? S_DONE : S_CAPTURE;
        end
        S_CAPTURE: begin
          if (sample_valid && dec_hit && (count_inc == len_sh)) nxt_state = S_DONE;
        end
        default: nxt_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    capture_trig = (cur_state == S_ARMED) && sample_valid && hit && !abort;
    capture_step = (cur_state == S_CAPTURE) && sample_valid && dec_hit && !abort;
    wr_en        = (capture_trig || capture_step) && !sys_rst;
    wr_addr      = capture_trig ? '0 : count[AW-1:0];
    wr_word      = {adc_ch1, adc_ch0};
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      mode_sh  <= M_IMM;
      level_sh <= '0;
      decim_sh <= '0;
      len_sh   <= FULL_DEPTH;
      prev_ok  <= 1'b0;
      prev_ch0 <= '0;
      dcnt     <= '0;
      count    <= '0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      busy_r <= (nxt_state == S_ARMED) || (nxt_state == S_CAPTURE);
      done_r <= (nxt_state == S_DONE);

      if (arm_take) begin
        mode_sh  <= trig_mode;
        level_sh <= trig_level;
        decim_sh <= decim;
        len_sh   <= (length == '0) ? FULL_DEPTH : {1'b0, length};
        prev_ok  <= 1'b0;
        dcnt     <= '0;
        count    <= '0;
      end

      // Previous sample only advances on valid samples, so gaps are transparent
      if ((cur_state == S_ARMED) && sample_valid && !abort) begin
        prev_ok  <= 1'b1;
        prev_ch0 <= adc_ch0;
      end

      if (capture_trig) begin
        count <= ONE_PAIR;
        dcnt  <= '0;
      end

      if ((cur_state == S_CAPTURE) && sample_valid && !abort) begin
        dcnt <= dec_hit ? 8'd0 : dcnt + 8'd1;
      end

      if (capture_step) begin
        count <= count_inc;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_word;
    end
  end

  // Read-first: a same-cycle write to rd_addr is seen on the following read
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rd_q <= '0;
    end else begin
      rd_q <= mem[rd_addr];
    end
  end

  assign state    = cur_state;
  assign busy     = busy_r;
  assign done     = done_r;
  assign wr_count = count;
  assign rd_data  = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_buffer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_adc_capture_buffer: random stimulus vs. window-level capture model  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_adc_capture_buffer;

  localparam int AW    = 10;
  localparam int DW    = 12;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] ch0, ch1;
  logic        valid, arm, abort, ext;
  logic [1:0]  mode;
  logic [11:0] level;
  logic [7:0]  decim;
  logic [9:0]  length;
  logic        busy, done;
  logic [1:0]  state;
  logic [10:0] wr_count;
  logic [9:0]  rd_addr;
  logic [23:0] rd_data;

  always #5 clk = ~clk;

  adc_capture_buffer #(.AW(AW), .DW(DW)) dut (
    .sys_clk(clk), .sys_rst(rst), .adc_ch0(ch0), .adc_ch1(ch1),
    .sample_valid(valid), .arm(arm), .abort(abort), .trig_mode(mode),
    .trig_level(level), .ext_trig(ext), .decim(decim), .length(length),
    .busy(busy), .done(done), .state(state), .wr_count(wr_count),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: expected RAM image plus the valid-sample history since arm
  logic [23:0] mm [DEPTH];
  bit          known [DEPTH];
  logic [11:0] q0[$];
  logic [11:0] q1[$];
  bit          qx[$];
  int c_mode, c_level, c_decim, c_len;
  bit recording = 1'b0;
  int stop_kind = 0;  // 0 running, 1 aborted, 2 reset

  logic [23:0] exp_q[$];
  int          addr_q[$];
  bit rd_issue = 1'b0;
  bit rd_pend  = 1'b0;

  function automatic logic [11:0] s12(int v);
    return v[11:0];
  endfunction

  function automatic int sx(logic [11:0] v);
    return int'($signed(v));
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Trigger index in the valid-sample history and number of pairs that must be stored
  task automatic model_eval(output int trig, output int cnt);
    trig = -1;
    cnt  = 0;
    for (int i = 0; i < q0.size(); i++) begin
      int cur, prv;
      cur = sx(q0[i]);
      prv = (i > 0) ? sx(q0[i-1]) : 0;
      case (c_mode)
        0: trig = i;
        1: if (i > 0 && prv < c_level && cur >= c_level) trig = i;
        2: if (i > 0 && prv > c_level && cur <= c_level) trig = i;
        default: if (qx[i]) trig = i;
      endcase
      if (trig >= 0) break;
    end
    if (trig >= 0) begin
      for (int k = 0; k < c_len; k++) begin
        int idx;
        idx = trig + k * (c_decim + 1);
        if (idx < q0.size()) begin
          mm[k]    = {q1[idx], q0[idx]};
          known[k] = 1'b1;
          cnt++;
        end
      end
    end
  endtask

  task automatic check_status(string tag);
    int t, c, es, ew, ed;
    model_eval(t, c);
    if (stop_kind == 1)      begin es = 0; ed = 0; ew = c; end
    else if (stop_kind == 2) begin es = 0; ed = 0; ew = 0; end
    else if (c == c_len)     begin es = 3; ed = 1; ew = c; end
    else if (t >= 0)         begin es = 2; ed = 0; ew = c; end
    else                     begin es = 1; ed = 0; ew = 0; end
    chk({tag, ".state"}, int'(state), es);
    chk({tag, ".done"}, int'(done), ed);
    chk({tag, ".wr_count"}, int'(wr_count), ew);
    chk({tag, ".busy"}, int'(busy), (es == 1 || es == 2) ? 1 : 0);
  endtask

  task automatic feed(bit v, int a, int b, bit x);
    valid = v; ch0 = s12(a); ch1 = s12(b); ext = x;
    tick();
    if (recording && v) begin
      q0.push_back(s12(a));
      q1.push_back(s12(b));
      qx.push_back(x);
    end
    valid = 1'b0;
  endtask

  task automatic do_arm(int md, int lv, int dc, int ln, bit v, int a, int b);
    mode = md[1:0]; level = s12(lv); decim = dc[7:0]; length = ln[9:0];
    arm = 1'b1; valid = v; ch0 = s12(a); ch1 = s12(b); ext = 1'b0;
    tick();
    arm = 1'b0; valid = 1'b0;
    c_mode = md; c_level = lv; c_decim = dc; c_len = (ln == 0) ? DEPTH : ln;
    q0.delete(); q1.delete(); qx.delete();
    recording = 1'b1; stop_kind = 0;
    // Scramble config inputs: only the latched copy may matter from here on
    mode = 2'($urandom); level = 12'($urandom); decim = 8'($urandom); length = 10'($urandom);
  endtask

  task automatic abort_cycle(bit v, int a, int b, bit with_arm);
    abort = 1'b1; arm = with_arm; valid = v; ch0 = s12(a); ch1 = s12(b);
    tick();
    abort = 1'b0; arm = 1'b0; valid = 1'b0;
    recording = 1'b0; stop_kind = 1;
  endtask

  task automatic reset_cycle(bit v, int a, int b);
    rst = 1'b1; valid = v; ch0 = s12(a); ch1 = s12(b);
    tick();
    rst = 1'b0; valid = 1'b0;
    recording = 1'b0; stop_kind = 2;
  endtask

  task automatic rd(int a);
    if (!known[a]) return;
    rd_addr = a[9:0];
    exp_q.push_back(mm[a]);
    addr_q.push_back(a);
    rd_issue = 1'b1;
    tick();
    rd_issue = 1'b0;
  endtask

  // Monitor: compares every registered read result against the scoreboard queue
  always @(posedge clk) rd_pend <= rd_issue;

  always @(negedge clk) begin
    if (rd_pend) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rd_data: read result with empty scoreboard, got %h", rd_data);
      end else begin
        logic [23:0] e;
        int          ad;
        e  = exp_q.pop_front();
        ad = addr_q.pop_front();
        if (rd_data !== e) begin
          bad++;
          $display("FAIL rd_data[%0d]: got %h expected %h", ad, rd_data, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its end, total=%0d", total);
    $fatal(1, "timeout");
  end

  initial begin
    int v;
    rst = 1'b1; ch0 = '0; ch1 = '0; valid = 1'b0; arm = 1'b0; abort = 1'b0; ext = 1'b0;
    mode = '0; level = '0; decim = '0; length = '0; rd_addr = '0;
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    tick(); tick(); tick();
    chk("reset.state", int'(state), 0);
    chk("reset.busy", int'(busy), 0);
    chk("reset.done", int'(done), 0);
    chk("reset.wr_count", int'(wr_count), 0);
    chk("reset.rd_data", int'(rd_data), 0);
    rst = 1'b0;
    tick();

    // Full-depth window (length=0)
    do_arm(0, 0, 0, 0, 1'b0, 0, 0);
    check_status("full.armed");
    for (int i = 0; i < DEPTH - 1; i++) feed(1'b1, i * 7 + 3, int'($urandom_range(0, 4095)), 1'b0);
    check_status("full.1023");
    feed(1'b1, 2047, 123, 1'b0);
    check_status("full.1024");
    for (int i = 0; i < 5; i++) feed(1'b1, -i - 1, 55, 1'b0);
    check_status("full.hold");
    rd(0); rd(1); rd(511); rd(1022); rd(1023);

    // Immediate mode on a per-cycle ramp, arm at cycle 10
    for (int c = 0; c < 10; c++) feed(1'b1, c, -c, 1'b0);
    do_arm(0, 0, 0, 4, 1'b1, 10, -10);
    for (int c = 11; c <= 13; c++) feed(1'b1, c, -c, 1'b0);
    check_status("imm.13");
    feed(1'b1, 14, -14, 1'b0);
    check_status("imm.14");
    for (int a = 0; a <= 4; a++) rd(a);

    // Rising crossing
    do_arm(1, 100, 0, 2, 1'b0, 0, 0);
    feed(1'b1, 90, 1, 1'b0);
    feed(1'b1, 99, 2, 1'b0);
    check_status("rise.armed");
    feed(1'b1, 100, 3, 1'b0);
    check_status("rise.trig");
    feed(1'b1, 101, 4, 1'b0);
    check_status("rise.done");
    rd(0); rd(1); rd(2);
    do_arm(1, 0, 0, 1, 1'b0, 0, 0);
    feed(1'b1, -5, 9, 1'b0);
    feed(1'b0, 50, 9, 1'b0);
    check_status("rise0.armed");
    feed(1'b1, 5, 8, 1'b0);
    check_status("rise0.done");
    rd(0); rd(1);

    // Falling crossing, then external trigger
    do_arm(2, 0, 0, 3, 1'b0, 0, 0);
    feed(1'b1, 10, 0, 1'b0);
    feed(1'b1, 0, 1, 1'b0);
    feed(1'b1, 7, 2, 1'b0);
    feed(1'b1, 8, 3, 1'b0);
    check_status("fall");
    for (int a = 0; a < 4; a++) rd(a);
    do_arm(3, 0, 0, 2, 1'b0, 0, 0);
    feed(1'b1, 20, 0, 1'b0);
    feed(1'b0, 21, 0, 1'b1);
    check_status("ext.armed");
    feed(1'b1, 22, 0, 1'b1);
    feed(1'b1, 23, 0, 1'b0);
    check_status("ext.done");
    rd(0); rd(1);

    // Decimation by 3 with a gap every other cycle
    do_arm(0, 0, 2, 3, 1'b0, 0, 0);
    v = 50;
    for (int c = 0; c < 16; c++) begin
      if (c % 2 == 0) begin
        feed(1'b1, v, 1000 + v, 1'b0);
        v++;
      end else begin
        feed(1'b0, int'($urandom_range(0, 4095)), 0, 1'b0);
      end
    end
    check_status("decim");
    for (int a = 0; a < 4; a++) rd(a);

    // Abort after two stores
    do_arm(0, 0, 0, 8, 1'b0, 0, 0);
    feed(1'b1, 300, 1, 1'b0);
    feed(1'b1, 301, 2, 1'b0);
    abort_cycle(1'b1, 302, 3, 1'b0);
    for (int c = 0; c < 3; c++) feed(1'b1, 303 + c, 4, 1'b0);
    check_status("abort");
    for (int a = 0; a < 4; a++) rd(a);

    // arm and abort in the same cycle from DONE
    do_arm(0, 0, 0, 2, 1'b1, 0, 0);
    feed(1'b1, 400, 0, 1'b0);
    feed(1'b1, 401, 0, 1'b0);
    check_status("aa.done");
    abort_cycle(1'b1, 402, 0, 1'b1);
    check_status("aa.idle");
    feed(1'b1, 403, 0, 1'b0);
    check_status("aa.stay");
    rd(0); rd(1); rd(2);

    // arm during CAPTURE must not disturb the latched config
    do_arm(0, 0, 1, 5, 1'b0, 0, 0);
    for (int c = 0; c < 3; c++) feed(1'b1, 500 + c, c, 1'b0);
    mode = 2'd1; level = 12'd2000; decim = 8'd0; length = 10'd2;
    arm = 1'b1;
    feed(1'b1, 503, 3, 1'b0);
    arm = 1'b0;
    for (int c = 4; c < 14; c++) feed(1'b1, 500 + c, c, 1'b0);
    check_status("rearm");
    for (int a = 0; a < 6; a++) rd(a);

    // Randomized captures
    for (int it = 0; it < 8; it++) begin
      abort_cycle(1'b0, 0, 0, 1'b0);
      check_status("rnd.pre");
      do_arm(int'($urandom_range(0, 3)), int'($urandom_range(0, 600)) - 300,
             int'($urandom_range(0, 3)), int'($urandom_range(1, 12)), 1'b0, 0, 0);
      for (int c = 0; c < 60; c++) begin
        feed($urandom_range(0, 3) != 0, int'($urandom_range(0, 4095)),
             int'($urandom_range(0, 4095)), $urandom_range(0, 9) == 0);
        if (c == 29) check_status("rnd.mid");
      end
      check_status("rnd.end");
      for (int a = 0; a < 12; a++) rd(a);
    end

    // sys_rst in the middle of a full-depth capture
    abort_cycle(1'b0, 0, 0, 1'b0);
    do_arm(0, 0, 0, 0, 1'b0, 0, 0);
    for (int c = 0; c < 20; c++) feed(1'b1, 700 + c, 3000 - c, 1'b0);
    check_status("rst.pre");
    reset_cycle(1'b1, 720, 0);
    check_status("rst.idle");
    for (int c = 0; c < 3; c++) feed(1'b1, 800 + c, 0, 1'b0);
    check_status("rst.stay");
    for (int a = 0; a < 25; a++) rd(a);

    tick(); tick(); tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d reads outstanding, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
